// File: rtl/counter_arbiter_if.sv
// Player request/response, round-clear and table-render signals of counter_arbiter.
interface counter_arbiter_if #(
  parameter int unsigned ITEM_W = 4
);
  logic              p1_req_in;
  logic              p1_op_in;
  logic [3:0]        p1_slot_in;
  logic [ITEM_W-1:0] p1_item_in;
  logic              p1_ack_out;
  logic              p1_ok_out;
  logic [ITEM_W-1:0] p1_item_out;

  logic              p2_req_in;
  logic              p2_op_in;
  logic [3:0]        p2_slot_in;
  logic [ITEM_W-1:0] p2_item_in;
  logic              p2_ack_out;
  logic              p2_ok_out;
  logic [ITEM_W-1:0] p2_item_out;

  logic              clear_in;
  logic [3:0]        render_slot_in;
  logic [ITEM_W-1:0] render_item_out;
  logic              busy_out;

  // Players, clear source and renderer.
  modport master (
    output p1_req_in, p1_op_in, p1_slot_in, p1_item_in,
    output p2_req_in, p2_op_in, p2_slot_in, p2_item_in,
    output clear_in, render_slot_in,
    input  p1_ack_out, p1_ok_out, p1_item_out,
    input  p2_ack_out, p2_ok_out, p2_item_out,
    input  render_item_out, busy_out
  );

  // The counter table itself.
  modport slave (
    input  p1_req_in, p1_op_in, p1_slot_in, p1_item_in,
    input  p2_req_in, p2_op_in, p2_slot_in, p2_item_in,
    input  clear_in, render_slot_in,
    output p1_ack_out, p1_ok_out, p1_item_out,
    output p2_ack_out, p2_ok_out, p2_item_out,
    output render_item_out, busy_out
  );
endinterface

// File: rtl/counter_arbiter.sv
// Shared counter table for two players: round-robin arbitration of place /
// pick-up transactions, round clear, and a registered render read port.
module counter_arbiter #(
  parameter int unsigned NUM_SLOTS = 16,
  parameter int unsigned ITEM_W    = 4
) (
  input  logic             pixel_clk_in,
  input  logic             rst_in,
  counter_arbiter_if.slave bus
);

  localparam int unsigned SLOT_W = 4;
  localparam int unsigned IDX_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_EXEC  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t            r_state;
  logic [ITEM_W-1:0] r_slots [NUM_SLOTS];

  // Tie-break pointer: set means the next contested grant goes to player 2.
  logic              r_tie_p2;
  logic              r_win_p2;
  logic              r_op;
  logic [SLOT_W-1:0] r_slot;
  logic [ITEM_W-1:0] r_item;
  logic [ITEM_W-1:0] r_hold;
  logic [ITEM_W-1:0] r_pick;
  logic              r_legal;

  logic              r_p1_ack;
  logic              r_p1_ok;
  logic [ITEM_W-1:0] r_p1_item;
  logic              r_p2_ack;
  logic              r_p2_ok;
  logic [ITEM_W-1:0] r_p2_item;
  logic              r_busy;
  logic [ITEM_W-1:0] r_render;

  logic              w_both_req;
  logic              w_any_req;
  logic              w_pick_p2;
  logic              w_slot_ok;
  logic [IDX_W-1:0]  w_idx;
  logic              w_place_ok;
  logic              w_pickup_ok;
  logic              w_render_ok;
  logic [IDX_W-1:0]  w_render_idx;

  // Arbitration: a lone requester wins; a tie goes to the player flagged by r_tie_p2.
  assign w_both_req = bus.p1_req_in & bus.p2_req_in;
  assign w_any_req  = bus.p1_req_in | bus.p2_req_in;
  assign w_pick_p2  = w_both_req ? r_tie_p2 : bus.p2_req_in;

  // Legality of the latched transaction, judged against the slot snapshot in r_hold.
  assign w_slot_ok   = (32'(r_slot) < NUM_SLOTS);
  assign w_idx       = r_slot[IDX_W-1:0];
  assign w_place_ok  = w_slot_ok && (r_hold == '0) && (r_item != '0);
  assign w_pickup_ok = w_slot_ok && (r_hold != '0);

  assign w_render_ok  = (32'(bus.render_slot_in) < NUM_SLOTS);
  assign w_render_idx = bus.render_slot_in[IDX_W-1:0];

  // Transaction FSM, slot array writes and registered player responses.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) r_slots[i] <= '0;
      r_tie_p2  <= 1'b0;
      r_win_p2  <= 1'b0;
      r_op      <= 1'b0;
      r_slot    <= '0;
      r_item    <= '0;
      r_hold    <= '0;
      r_pick    <= '0;
      r_legal   <= 1'b0;
      r_p1_ack  <= 1'b0;
      r_p1_ok   <= 1'b0;
      r_p1_item <= '0;
      r_p2_ack  <= 1'b0;
      r_p2_ok   <= 1'b0;
      r_p2_item <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_p1_ack  <= 1'b0;
      r_p1_ok   <= 1'b0;
      r_p1_item <= '0;
      r_p2_ack  <= 1'b0;
      r_p2_ok   <= 1'b0;
      r_p2_item <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.clear_in) begin
            for (int i = 0; i < NUM_SLOTS; i++) r_slots[i] <= '0;
          end else if (w_any_req) begin
            r_win_p2 <= w_pick_p2;
            if (w_both_req) r_tie_p2 <= ~w_pick_p2;
            r_op     <= w_pick_p2 ? bus.p2_op_in   : bus.p1_op_in;
            r_slot   <= w_pick_p2 ? bus.p2_slot_in : bus.p1_slot_in;
            r_item   <= w_pick_p2 ? bus.p2_item_in : bus.p1_item_in;
            r_busy   <= 1'b1;
            r_state  <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_hold  <= w_slot_ok ? r_slots[w_idx] : '0;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (!r_op) begin
            r_legal <= w_place_ok;
            r_pick  <= '0;
            if (w_place_ok) r_slots[w_idx] <= r_item;
          end else begin
            r_legal <= w_pickup_ok;
            r_pick  <= w_pickup_ok ? r_hold : '0;
            if (w_pickup_ok) r_slots[w_idx] <= '0;
          end
          r_state <= S_ACK;
        end
        S_ACK: begin
          if (r_win_p2) begin
            r_p2_ack  <= 1'b1;
            r_p2_ok   <= r_legal;
            r_p2_item <= r_pick;
          end else begin
            r_p1_ack  <= 1'b1;
            r_p1_ok   <= r_legal;
            r_p1_item <= r_pick;
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Render read port: one-cycle registered lookup, zero for out-of-range slots.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_render <= '0;
    end else begin
      r_render <= w_render_ok ? r_slots[w_render_idx] : '0;
    end
  end

  assign bus.p1_ack_out      = r_p1_ack;
  assign bus.p1_ok_out       = r_p1_ok;
  assign bus.p1_item_out     = r_p1_item;
  assign bus.p2_ack_out      = r_p2_ack;
  assign bus.p2_ok_out       = r_p2_ok;
  assign bus.p2_item_out     = r_p2_item;
  assign bus.render_item_out = r_render;
  assign bus.busy_out        = r_busy;

endmodule
